sos_board_engine: RTL and testbench

Parametrised SOS game engine for an ROWS x COLS board. Each move is accepted through a valid/ready handshake and checked for legality. A legal move is written to the board, then a sequential 8-direction scan counts the new S-O-S lines through the placed cell. The engine then updates the scores, the turn and the game-over state. It sits between the switch/key move-entry logic and the VGA/HEX display logic, which reads the board through a combinational read port.

---
 rtl/sos_pkg.sv | 40 ++++
 rtl/sos_line_check.sv | 27 ++
 rtl/sos_board_engine.sv | 199 +++++++++++++++++++
 tb/tb_sos_board_engine.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// Shared definitions for the SOS board engine: cell and winner codes,
// controller states and the 8-direction offset table.
package sos_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_S     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PLACE,
    ST_SCAN,
    ST_UPDATE
  } state_t;

  // Row offset for direction d in the order N, NE, E, SE, S, SW, W, NW.
  function automatic logic signed [1:0] dir_drow(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dir_drow = 2'sb11;
      3'd3, 3'd4, 3'd5: dir_drow = 2'sb01;
      default:          dir_drow = 2'sb00;
    endcase
  endfunction

  // Column offset for direction d in the same order.
  function automatic logic signed [1:0] dir_dcol(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dcol = 2'sb01;
      3'd5, 3'd6, 3'd7: dir_dcol = 2'sb11;
      default:          dir_dcol = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/sos_line_check.sv
// Match test for one scan direction. back is cell-d, fwd1 is cell+d and
// fwd2 is cell+2d; an out-of-range neighbour never matches.
module sos_line_check (
  input  logic [1:0] letter_i,
  input  logic       primary_dir_i,
  input  logic [1:0] back_i,
  input  logic       back_ok_i,
  input  logic [1:0] fwd1_i,
  input  logic       fwd1_ok_i,
  input  logic [1:0] fwd2_i,
  input  logic       fwd2_ok_i,
  output logic       match_o
);
  import sos_pkg::*;

  // S starts a line outward; O sits in the middle and only looks along the
  // first four directions so that each line through it counts once.
  always_comb begin
    match_o = 1'b0;
    if (letter_i == CELL_S) begin
      match_o = fwd1_ok_i && fwd2_ok_i && (fwd1_i == CELL_O) && (fwd2_i == CELL_S);
    end else if ((letter_i == CELL_O) && primary_dir_i) begin
      match_o = back_ok_i && fwd1_ok_i && (back_i == CELL_S) && (fwd1_i == CELL_S);
    end
  end

endmodule

// File: rtl/sos_board_engine.sv
// SOS game engine: handshake move entry, legality check, board write,
// sequential 8-direction line scan, then score/turn/game-over update.
module sos_board_engine #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int SCORE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               new_game,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [2:0]         move_row,
  input  logic [2:0]         move_col,
  input  logic [1:0]         move_letter,
  output logic               move_illegal,
  output logic               move_done,
  output logic [3:0]         sos_found,
  output logic               current_player,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic [1:0]         winner,
  input  logic [2:0]         rd_row,
  input  logic [2:0]         rd_col,
  output logic [1:0]         rd_cell
);
  import sos_pkg::*;

  localparam int                CELLS     = ROWS * COLS;
  localparam int                SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int                SUM_W     = ((SCORE_W > 4) ? SCORE_W : 4) + 1;
  localparam logic signed [4:0] ROWS_S    = 5'(ROWS);
  localparam logic signed [4:0] COLS_S    = 5'(COLS);

  state_t               state_q, state_d;
  logic [1:0]           board_q [ROWS][COLS];
  logic [2:0]           row_q, col_q, dir_q;
  logic [1:0]           let_q;
  logic [3:0]           acc_q, sos_q;
  logic [6:0]           filled_q;
  logic [SCORE_W-1:0]   p1_q, p2_q;
  logic                 player_q, over_q;
  logic [1:0]           winner_q;

  logic                 clear, illegal, match;
  logic signed [1:0]    dr, dc;
  logic signed [4:0]    dr5, dc5, r0, c0, r1, c1, r2, c2, rb, cb;
  logic [SUM_W-1:0]     sum;
  logic [SCORE_W-1:0]   sat, p1_new, p2_new;
  logic [1:0]           winner_new;

  function automatic logic in_range(input logic signed [4:0] r, input logic signed [4:0] c);
    in_range = (r >= 5'sd0) && (r < ROWS_S) && (c >= 5'sd0) && (c < COLS_S);
  endfunction

  // Coordinates that miss every cell (negative or too large) read as empty.
  function automatic logic [1:0] cell_at(input logic signed [4:0] r, input logic signed [4:0] c);
    cell_at = CELL_EMPTY;
    for (int unsigned ri = 0; ri < ROWS; ri++) begin
      for (int unsigned ci = 0; ci < COLS; ci++) begin
        if ((r == 5'(ri)) && (c == 5'(ci))) cell_at = board_q[ri][ci];
      end
    end
  endfunction

  assign clear          = Reset || new_game;
  assign sos_found      = sos_q;
  assign current_player = player_q;
  assign score_p1       = p1_q;
  assign score_p2       = p2_q;
  assign game_over      = over_q;
  assign winner         = winner_q;

  // Display read port and neighbour coordinates for the current scan step.
  always_comb begin
    rd_cell = cell_at($signed({2'b00, rd_row}), $signed({2'b00, rd_col}));
    dr      = dir_drow(dir_q);
    dc      = dir_dcol(dir_q);
    dr5     = {{3{dr[1]}}, dr};
    dc5     = {{3{dc[1]}}, dc};
    r0      = $signed({2'b00, row_q});
    c0      = $signed({2'b00, col_q});
    r1      = r0 + dr5;
    c1      = c0 + dc5;
    r2      = r1 + dr5;
    c2      = c1 + dc5;
    rb      = r0 - dr5;
    cb      = c0 - dc5;
    illegal = !in_range(r0, c0) || ((let_q != CELL_S) && (let_q != CELL_O)) ||
              (cell_at(r0, c0) != CELL_EMPTY);
  end

  sos_line_check u_line_check (
    .letter_i      (let_q),
    .primary_dir_i (~dir_q[2]),
    .back_i        (cell_at(rb, cb)),
    .back_ok_i     (in_range(rb, cb)),
    .fwd1_i        (cell_at(r1, c1)),
    .fwd1_ok_i     (in_range(r1, c1)),
    .fwd2_i        (cell_at(r2, c2)),
    .fwd2_ok_i     (in_range(r2, c2)),
    .match_o       (match)
  );

  // Saturating score update for the mover and the resulting winner.
  always_comb begin
    sum    = player_q ? SUM_W'(p2_q) : SUM_W'(p1_q);
    sum    = sum + SUM_W'(acc_q);
    sat    = (sum > SUM_W'(SCORE_MAX)) ? '1 : SCORE_W'(sum);
    p1_new = player_q ? p1_q : sat;
    p2_new = player_q ? sat : p2_q;
    if (p1_new > p2_new)      winner_new = WIN_P1;
    else if (p1_new < p2_new) winner_new = WIN_P2;
    else                      winner_new = WIN_DRAW;
  end

  // Next-state and handshake/pulse outputs; a clear suppresses all pulses.
  always_comb begin
    state_d      = state_q;
    move_ready   = 1'b0;
    move_illegal = 1'b0;
    move_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        move_ready = !over_q;
        if (move_valid && !over_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        move_illegal = illegal && !clear;
        state_d      = illegal ? ST_IDLE : ST_PLACE;
      end
      ST_PLACE:  state_d = ST_SCAN;
      ST_SCAN:   if (dir_q == 3'd7) state_d = ST_UPDATE;
      ST_UPDATE: begin
        move_done = !clear;
        state_d   = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // State register and game datapath.
  always_ff @(posedge Clock) begin
    state_q <= state_d;
    if (clear) begin
      for (int unsigned ri = 0; ri < ROWS; ri++)
        for (int unsigned ci = 0; ci < COLS; ci++)
          board_q[ri][ci] <= CELL_EMPTY;
      row_q    <= '0;
      col_q    <= '0;
      let_q    <= '0;
      dir_q    <= '0;
      acc_q    <= '0;
      sos_q    <= '0;
      filled_q <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move_valid && !over_q) begin
            row_q <= move_row;
            col_q <= move_col;
            let_q <= move_letter;
          end
        end
        ST_PLACE: begin
          for (int unsigned ri = 0; ri < ROWS; ri++)
            for (int unsigned ci = 0; ci < COLS; ci++)
              if ((r0 == 5'(ri)) && (c0 == 5'(ci))) board_q[ri][ci] <= let_q;
          filled_q <= filled_q + 7'd1;
          acc_q    <= '0;
          dir_q    <= '0;
        end
        ST_SCAN: begin
          acc_q <= acc_q + {3'b000, match};
          dir_q <= dir_q + 3'd1;
        end
        ST_UPDATE: begin
          sos_q <= acc_q;
          p1_q  <= p1_new;
          p2_q  <= p2_new;
          if (acc_q == 4'd0) player_q <= !player_q;
          if (filled_q == 7'(CELLS)) begin
            over_q   <= 1'b1;
            winner_q <= winner_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sos_board_engine.sv
// Bench for sos_board_engine: a 3x3 and a 4x5 instance share one stimulus
// path (selected by sel) and are checked against a board-level game model.
module tb_sos_board_engine;

  logic       Clock = 1'b0;
  logic       Reset, ng, mv_valid, sel;
  logic [2:0] mv_row, mv_col, rd_row, rd_col;
  logic [1:0] mv_letter;

  logic       rdy_a, ill_a, done_a, cp_a, go_a, rdy_b, ill_b, done_b, cp_b, go_b;
  logic [3:0] sos_a, p1_a, p2_a, sos_b, p1_b, p2_b;
  logic [1:0] win_a, cell_a, win_b, cell_b;

  logic       move_ready, move_illegal, move_done, current_player, game_over;
  logic [3:0] sos_found, score_p1, score_p2;
  logic [1:0] winner, rd_cell;

  always #5 Clock = ~Clock;

  sos_board_engine #(.ROWS(3), .COLS(3), .SCORE_W(4)) dut_a (
    .Clock(Clock), .Reset(Reset), .new_game(ng & ~sel), .move_valid(mv_valid & ~sel),
    .move_ready(rdy_a), .move_row(mv_row), .move_col(mv_col), .move_letter(mv_letter),
    .move_illegal(ill_a), .move_done(done_a), .sos_found(sos_a), .current_player(cp_a),
    .score_p1(p1_a), .score_p2(p2_a), .game_over(go_a), .winner(win_a),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(cell_a));

  sos_board_engine #(.ROWS(4), .COLS(5), .SCORE_W(4)) dut_b (
    .Clock(Clock), .Reset(Reset), .new_game(ng & sel), .move_valid(mv_valid & sel),
    .move_ready(rdy_b), .move_row(mv_row), .move_col(mv_col), .move_letter(mv_letter),
    .move_illegal(ill_b), .move_done(done_b), .sos_found(sos_b), .current_player(cp_b),
    .score_p1(p1_b), .score_p2(p2_b), .game_over(go_b), .winner(win_b),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(cell_b));

  assign move_ready     = sel ? rdy_b  : rdy_a;
  assign move_illegal   = sel ? ill_b  : ill_a;
  assign move_done      = sel ? done_b : done_a;
  assign sos_found      = sel ? sos_b  : sos_a;
  assign current_player = sel ? cp_b   : cp_a;
  assign score_p1       = sel ? p1_b   : p1_a;
  assign score_p2       = sel ? p2_b   : p2_a;
  assign game_over      = sel ? go_b   : go_a;
  assign winner         = sel ? win_b  : win_a;
  assign rd_cell        = sel ? cell_b : cell_a;

  // ---------------- game model ----------------
  int checks = 0;
  int errors = 0;
  int mb [8][8];
  int m_rows, m_cols, m_p1, m_p2, m_player, m_filled, m_go, m_win, m_sos;
  bit model_valid = 1'b0;

  function automatic int mcell(int r, int c);
    if (r < 0 || r >= m_rows || c < 0 || c >= m_cols) return 0;
    return mb[r][c];
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = 0;
    m_p1 = 0; m_p2 = 0; m_player = 0; m_filled = 0; m_go = 0; m_win = 0; m_sos = 0;
  endfunction

  // Lines completed by the letter just placed at (r,c).
  function automatic int count_sos(int r, int c);
    int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int n = 0;
    if (mb[r][c] == 1) begin
      for (int d = 0; d < 8; d++)
        if (mcell(r + dr[d], c + dc[d]) == 2 && mcell(r + 2*dr[d], c + 2*dc[d]) == 1) n++;
    end else begin
      for (int d = 0; d < 4; d++)
        if (mcell(r - dr[d], c - dc[d]) == 1 && mcell(r + dr[d], c + dc[d]) == 1) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every idle cycle: outputs and a random read-port address against the model.
  initial begin
    rd_row = '0; rd_col = '0;
    forever begin
      @(negedge Clock);
      rd_row = 3'($urandom_range(0, 7));
      rd_col = 3'($urandom_range(0, 7));
      #1;
      if (model_valid) begin
        chk("score_p1", score_p1, m_p1);
        chk("score_p2", score_p2, m_p2);
        chk("current_player", current_player, m_player);
        chk("game_over", game_over, m_go);
        chk("winner", winner, m_go ? m_win : 0);
        chk("sos_found", sos_found, m_sos);
        chk("move_ready", move_ready, m_go ? 0 : 1);
        chk("rd_cell", rd_cell, mcell(int'(rd_row), int'(rd_col)));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_move(input int r, input int c, input int l, output int found);
    int exp_ill, n, cur;
    exp_ill = (r >= m_rows || c >= m_cols || (l != 1 && l != 2) || mcell(r, c) != 0) ? 1 : 0;
    @(negedge Clock);
    model_valid = 1'b0;
    chk("ready_before_move", move_ready, 1);
    mv_valid = 1'b1; mv_row = 3'(r); mv_col = 3'(c); mv_letter = 2'(l);
    @(negedge Clock);
    mv_valid = 1'b0;
    chk("illegal_at_T1", move_illegal, exp_ill);
    chk("done_at_T1", move_done, 0);
    if (exp_ill != 0) begin
      found = -1;
      @(negedge Clock);
      chk("ready_at_T2", move_ready, 1);
      chk("illegal_single_pulse", move_illegal, 0);
      model_valid = 1'b1;
    end else begin
      n = 1;
      while (!move_done && n < 20) begin
        @(negedge Clock);
        n++;
      end
      chk("handshake_to_done_latency", n, 11);
      mb[r][c] = l;
      m_filled++;
      found = count_sos(r, c);
      cur = (m_player != 0) ? m_p2 : m_p1;
      cur = (cur + found > 15) ? 15 : cur + found;
      if (m_player != 0) m_p2 = cur; else m_p1 = cur;
      if (found == 0) m_player ^= 1;
      m_sos = found;
      if (m_filled == m_rows * m_cols) begin
        m_go  = 1;
        m_win = (m_p1 > m_p2) ? 1 : (m_p1 < m_p2) ? 2 : 3;
      end
      @(negedge Clock);
      chk("done_single_pulse", move_done, 0);
      model_valid = 1'b1;
    end
  endtask

  task automatic start_new(input int with_move);
    @(negedge Clock);
    model_valid = 1'b0;
    ng = 1'b1;
    if (with_move != 0) begin
      mv_valid = 1'b1; mv_row = 3'd0; mv_col = 3'd0; mv_letter = 2'd1;
    end
    @(negedge Clock);
    ng = 1'b0; mv_valid = 1'b0;
    model_clear();
    model_valid = 1'b1;
    chk("new_game_no_illegal", move_illegal, 0);
    chk("new_game_ready", move_ready, 1);
  endtask

  task automatic try_ignored(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      mv_valid = 1'b1;
      mv_row = 3'($urandom_range(0, 2)); mv_col = 3'($urandom_range(0, 2));
      mv_letter = 2'($urandom_range(1, 2));
      #1;
      chk("ignored_ready_low", move_ready, 0);
      chk("ignored_no_illegal", move_illegal, 0);
      chk("ignored_no_done", move_done, 0);
    end
    @(negedge Clock);
    mv_valid = 1'b0;
  endtask

  task automatic random_game();
    int f, r, c, l, k, tries;
    tries = 0;
    while (m_go == 0 && tries < 150) begin
      tries++;
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, m_rows); c = $urandom_range(0, m_cols); l = $urandom_range(0, 3);
      end else begin
        k = $urandom_range(0, m_rows * m_cols - m_filled - 1);
        r = 0; c = 0;
        for (int i = 0; i < m_rows * m_cols; i++) begin
          if (mb[i / m_cols][i % m_cols] == 0) begin
            if (k == 0) begin r = i / m_cols; c = i % m_cols; end
            k--;
          end
        end
        l = $urandom_range(1, 2);
      end
      do_move(r, c, l, f);
    end
    chk("random_game_reaches_over", game_over, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f;
    bit seen;
    Reset = 1'b1; ng = 1'b0; mv_valid = 1'b0; sel = 1'b0;
    mv_row = '0; mv_col = '0; mv_letter = '0;
    m_rows = 3; m_cols = 3;
    model_clear();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    model_valid = 1'b1;
    chk("reset_ready", move_ready, 1);
    chk("reset_score_p1", score_p1, 0);
    chk("reset_winner", winner, 0);

    // no line, turn toggles
    do_move(0, 0, 1, f);
    chk("t1_sos", sos_found, 0);
    chk("t1_player", current_player, 1);
    do_move(1, 1, 2, f);
    chk("t1_player_back", current_player, 0);
    // diagonal line, same player again
    do_move(2, 2, 1, f);
    chk("t2_model_count", f, 1);
    chk("t2_sos", sos_found, 1);
    chk("t2_score_p1", score_p1, 1);
    chk("t2_player", current_player, 0);
    // illegal moves
    do_move(0, 0, 2, f); chk("t4_occupied", f, -1);
    do_move(3, 0, 1, f); chk("t4_row_oob", f, -1);
    do_move(0, 1, 3, f); chk("t4_letter_11", f, -1);
    do_move(0, 1, 0, f); chk("t4_letter_00", f, -1);
    do_move(0, 3, 2, f); chk("t4_col_oob", f, -1);
    chk("t4_player_kept", current_player, 0);
    chk("t4_score_kept", score_p1, 1);

    // double line through an O
    start_new(0);
    do_move(1, 0, 1, f); do_move(1, 2, 1, f); do_move(0, 1, 1, f); do_move(2, 1, 1, f);
    do_move(1, 1, 2, f);
    chk("t3_model_count", f, 2);
    chk("t3_sos", sos_found, 2);
    chk("t3_score_p1", score_p1, 2);

    // full board of O: draw, then further moves ignored
    start_new(0);
    for (int i = 0; i < 9; i++) do_move(i / 3, i % 3, 2, f);
    chk("t5_game_over", game_over, 1);
    chk("t5_winner_draw", winner, 3);
    chk("t5_ready_low", move_ready, 0);
    try_ignored(4);

    // new_game wins over a simultaneous move
    start_new(1);
    seen = 1'b0;
    repeat (14) begin @(negedge Clock); seen |= move_done | move_illegal; end
    chk("collide_no_pulse", seen, 0);
    do_move(0, 0, 1, f);
    chk("collide_cell_was_empty", f, 0);

    for (int g = 0; g < 3; g++) begin
      start_new(0);
      random_game();
    end

    // 4x5 instance
    @(negedge Clock);
    model_valid = 1'b0;
    sel = 1'b1; m_rows = 4; m_cols = 5;
    start_new(0);
    do_move(1, 0, 2, f); do_move(2, 1, 1, f);
    do_move(0, 4, 1, f);
    chk("t6_no_wrap_model", f, 0);
    chk("t6_no_wrap_sos", sos_found, 0);
    // reset during the scan of the next move
    @(negedge Clock);
    model_valid = 1'b0;
    mv_valid = 1'b1; mv_row = 3'd3; mv_col = 3'd3; mv_letter = 2'd1;
    @(negedge Clock);
    mv_valid = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_clear();
    model_valid = 1'b1;
    seen = 1'b0;
    repeat (14) begin @(negedge Clock); seen |= move_done; end
    chk("t6_no_done_after_reset", seen, 0);
    chk("t6_scores_cleared", score_p1 + score_p2, 0);
    do_move(3, 3, 1, f);
    chk("t6_cell_cleared", f, 0);

    for (int g = 0; g < 3; g++) begin
      start_new(0);
      random_game();
    end

    repeat (2) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
